// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA pixel path.
package vga_pkg;

    localparam int H_ACTIVE       = 640;
    localparam int V_ACTIVE       = 480;
    localparam int V_TOTAL        = 525;
    localparam int WORDS_PER_LINE = 20;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        GAP
    } fetch_state_t;

    // Word offset of a line's first word, L*20 built from two shifts.
    function automatic logic [13:0] line_offset(input logic [8:0] l);
        line_offset = ({5'b0, l} << 4) + ({5'b0, l} << 2);
    endfunction

endpackage

// File: rtl/vga_line_fetcher_if.sv
// Framebuffer read port between the line fetcher (master) and the memory (slave).
interface vga_line_fetcher_if #(
    parameter int ADDR_W = 16
);
    // Handshake: the master holds mem_req and mem_addr unchanged until it samples
    // mem_ack high on a clock edge; mem_rdata is valid in that same ack cycle.
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/vga_line_fetcher_line_buffer.sv
// Ping-pong line store: two lines of 20 x 32-bit words, sync write, comb read.
module line_buffer
    import vga_pkg::*;
(
    input  logic        clk_i,
    input  logic        we_i,
    input  logic        wr_b_i,
    input  logic [4:0]  wr_w_i,
    input  logic [31:0] wr_data_i,
    input  logic        rd_b_i,
    input  logic [4:0]  rd_w_i,
    output logic [31:0] rd_data_o
);

    logic [31:0] mem_q [2][WORDS_PER_LINE];

    always_ff @(posedge clk_i) begin
        if (we_i && (wr_w_i < 5'(WORDS_PER_LINE))) begin
            mem_q[wr_b_i][wr_w_i] <= wr_data_i;
        end
    end

    // Word indices past the line end come from blanking x and read as zero.
    assign rd_data_o = (rd_w_i < 5'(WORDS_PER_LINE)) ? mem_q[rd_b_i][rd_w_i] : 32'b0;

endmodule

// File: rtl/vga_line_fetcher.sv
// Prefetches the next display line from the framebuffer into a ping-pong buffer
// and returns the registered 1bpp pixel for the current coordinate.
module vga_line_fetcher
    import vga_pkg::*;
#(
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned ADDR_W    = 16
) (
    input  logic                      CLOCK_50,
    input  logic                      nReset,
    input  logic [9:0]                pixel_x,
    input  logic [9:0]                pixel_y,
    output logic [9:0]                pixel,
    output logic                      overrun,
    output fetch_state_t              dbg_state_o,
    vga_line_fetcher_if.master        mem
);

    fetch_state_t      state_q;
    logic              pending_q;
    logic [9:0]        prev_y_q;
    logic [1:0]        valid_q;
    logic [8:0]        line_q;
    logic [4:0]        word_q;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic              overrun_q;
    logic              pix_q;

    logic              fetch_ev;
    logic [9:0]        tgt_line;
    logic              tgt_ok;
    logic              buf_we;
    logic [31:0]       rd_word;
    logic              pix_d;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [8:0] l, input logic [4:0] w);
        word_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(line_offset(l)) + ADDR_W'(w);
    endfunction

    assign fetch_ev = pending_q || (pixel_y != prev_y_q);
    assign tgt_line = (pixel_y == 10'(V_TOTAL - 1)) ? 10'd0 : pixel_y + 10'd1;
    assign tgt_ok   = tgt_line < 10'(V_ACTIVE);
    // A fetch event in the same cycle as an ack abandons that word's data.
    assign buf_we   = (state_q == FETCH) && mem.mem_ack && !fetch_ev;

    line_buffer u_line_buffer (
        .clk_i     (CLOCK_50),
        .we_i      (buf_we),
        .wr_b_i    (line_q[0]),
        .wr_w_i    (word_q),
        .wr_data_i (mem.mem_rdata),
        .rd_b_i    (pixel_y[0]),
        .rd_w_i    (pixel_x[9:5]),
        .rd_data_o (rd_word)
    );

    assign pix_d = (pixel_x < 10'(H_ACTIVE)) && (pixel_y < 10'(V_ACTIVE))
                   && valid_q[pixel_y[0]] && rd_word[pixel_x[4:0]];

    always_ff @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset) begin
            state_q   <= IDLE;
            pending_q <= 1'b1;
            prev_y_q  <= '0;
            valid_q   <= '0;
            line_q    <= '0;
            word_q    <= '0;
            req_q     <= 1'b0;
            addr_q    <= '0;
            overrun_q <= 1'b0;
            pix_q     <= 1'b0;
        end else begin
            pending_q <= 1'b0;
            prev_y_q  <= pixel_y;
            pix_q     <= pix_d;
            if (fetch_ev && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end
            // A fetch event always (re)starts from word 0, abandoning any fetch in flight.
            if (fetch_ev) begin
                if (tgt_ok) begin
                    state_q               <= FETCH;
                    line_q                <= tgt_line[8:0];
                    word_q                <= '0;
                    valid_q[tgt_line[0]]  <= 1'b0;
                    req_q                 <= 1'b1;
                    addr_q                <= word_addr(tgt_line[8:0], 5'd0);
                end else begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            end else begin
                case (state_q)
                    FETCH: begin
                        if (mem.mem_ack) begin
                            req_q <= 1'b0;
                            if (word_q == 5'(WORDS_PER_LINE - 1)) begin
                                valid_q[line_q[0]] <= 1'b1;
                                state_q            <= IDLE;
                            end else begin
                                state_q <= GAP;
                            end
                        end
                    end
                    GAP: begin
                        word_q  <= word_q + 5'd1;
                        req_q   <= 1'b1;
                        addr_q  <= word_addr(line_q, word_q + 5'd1);
                        state_q <= FETCH;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign mem.mem_req  = req_q;
    assign mem.mem_addr = addr_q;
    assign pixel        = {9'b0, pix_q};
    assign overrun      = overrun_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_vga_line_fetcher.sv
// Bench for vga_line_fetcher: pixel vector table, hand-written fetch/overrun/reset
// sequences, and randomized line steps checked against a line-to-buffer model.
module tb_vga_line_fetcher;
    import vga_pkg::*;

    localparam int ADDR_W   = 16;
    localparam int BASE     = 256;
    localparam int FB_WORDS = 480 * 20;

    logic         CLOCK_50 = 1'b0;
    logic         nReset;
    logic [9:0]   pixel_x;
    logic [9:0]   pixel_y;
    logic [9:0]   pixel;
    logic         overrun;
    fetch_state_t dbg_state;

    vga_line_fetcher_if #(.ADDR_W(ADDR_W)) mem_if ();

    vga_line_fetcher #(.BASE_ADDR(BASE), .ADDR_W(ADDR_W)) dut (
        .CLOCK_50    (CLOCK_50),
        .nReset      (nReset),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .pixel       (pixel),
        .overrun     (overrun),
        .dbg_state_o (dbg_state),
        .mem         (mem_if)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int errors = 0;
    int checks = 0;

    // Framebuffer contents and memory responder controls.
    logic [31:0] fb [FB_WORDS];
    int  ack_delay   = 0;
    bit  ack_rand    = 1'b0;
    bit  ack_hold    = 1'b0;
    int  relatch_cnt = 0;

    // Responder-owned state.
    int                wait_cnt     = 0;
    int                cur_delay    = 0;
    bit                req_seen     = 1'b0;
    int                relatch_seen = 0;
    logic [ADDR_W-1:0] held_addr    = '0;
    int                req_cycles   = 0;
    int                rises        = 0;
    logic [ADDR_W-1:0] ack_log [$];
    logic [ADDR_W-1:0] held_log [$];

    // Scoreboard / model state.
    logic [ADDR_W-1:0] exp_q [$];
    int model_line [2];
    int cur_y;
    int rise_mark, cyc_mark, log_mark;

    typedef struct {
        int   x;
        int   y;
        logic exp;
    } vec_t;
    vec_t vecs [12];

    function automatic logic [31:0] fb_word(input logic [ADDR_W-1:0] a);
        int idx;
        idx = int'(a) - BASE;
        if (idx >= 0 && idx < FB_WORDS) return fb[idx];
        return 32'hDEAD_BEEF;
    endfunction

    // Pixel seen on screen: whichever complete line the row's buffer holds, else black.
    function automatic logic exp_pix(input int x, input int y);
        int l;
        logic [31:0] word;
        l = model_line[y % 2];
        if (x >= 640 || y >= 480 || l < 0) return 1'b0;
        word = fb[l * 20 + x / 32];
        return word[x % 32];
    endfunction

    always @(negedge CLOCK_50) begin
        if (!nReset || !mem_if.mem_req) begin
            mem_if.mem_ack   = 1'b0;
            mem_if.mem_rdata = $urandom();
            wait_cnt         = 0;
            req_seen         = 1'b0;
            cur_delay        = ack_rand ? int'($urandom_range(0, 3)) : ack_delay;
        end else begin
            if (!req_seen) begin
                req_seen  = 1'b1;
                rises++;
                held_addr = mem_if.mem_addr;
            end
            if (relatch_seen != relatch_cnt) begin
                relatch_seen = relatch_cnt;
                held_addr    = mem_if.mem_addr;
            end
            req_cycles++;
            if (!ack_hold && wait_cnt >= cur_delay) begin
                mem_if.mem_ack   = 1'b1;
                mem_if.mem_rdata = fb_word(mem_if.mem_addr);
                ack_log.push_back(mem_if.mem_addr);
                held_log.push_back(held_addr);
            end else begin
                mem_if.mem_ack   = 1'b0;
                mem_if.mem_rdata = $urandom();
                wait_cnt++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic mark();
        rise_mark = rises;
        cyc_mark  = req_cycles;
        log_mark  = ack_log.size();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        tick(1);
        while (dbg_state != IDLE && n < 1000) begin
            tick(1);
            n++;
        end
        check("fetch_done_in_budget", 32'(n < 1000), 32'd1);
    endtask

    task automatic step_y(input int y, input bit wait_done);
        int l;
        bit changed;
        changed = (y != cur_y);
        l = (y == 524) ? 0 : y + 1;
        pixel_y = 10'(y);
        if (changed && l < 480) model_line[l % 2] = -1;
        cur_y = y;
        if (wait_done) begin
            wait_idle();
            if (changed && l < 480) model_line[l % 2] = l;
        end
    endtask

    task automatic read_px(input string name, input int x, input logic exp);
        pixel_x = 10'(x);
        tick(1);
        check(name, 32'(pixel), {31'b0, exp});
    endtask

    task automatic check_fetch(input string name, input int l);
        int n;
        n = ack_log.size() - log_mark;
        exp_q.delete();
        for (int w = 0; w < 20; w++) exp_q.push_back(ADDR_W'(BASE + l * 20 + w));
        check({name, "_count"}, 32'(n), 32'(exp_q.size()));
        for (int w = 0; w < n && exp_q.size() > 0; w++) begin
            check({name, "_addr"}, 32'(ack_log[log_mark + w]), 32'(exp_q.pop_front()));
            check({name, "_stable"}, 32'(ack_log[log_mark + w]), 32'(held_log[log_mark + w]));
        end
    endtask

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int x;
        int y;

        nReset  = 1'b0;
        pixel_x = '0;
        pixel_y = '0;
        cur_y   = 0;
        model_line[0] = -1;
        model_line[1] = -1;
        for (int i = 0; i < FB_WORDS; i++) fb[i] = $urandom();
        fb[40] = 32'h0000_0001;
        fb[41] = 32'h8000_0000;
        for (int i = 42; i < 59; i++) fb[i] = 32'h0;
        fb[59] = 32'h8000_0001;

        vecs[0]  = '{0,   2, 1'b1};
        vecs[1]  = '{1,   2, 1'b0};
        vecs[2]  = '{31,  2, 1'b0};
        vecs[3]  = '{32,  2, 1'b0};
        vecs[4]  = '{63,  2, 1'b1};
        vecs[5]  = '{64,  2, 1'b0};
        vecs[6]  = '{608, 2, 1'b1};
        vecs[7]  = '{638, 2, 1'b0};
        vecs[8]  = '{639, 2, 1'b1};
        vecs[9]  = '{640, 2, 1'b0};
        vecs[10] = '{700, 2, 1'b0};
        vecs[11] = '{799, 2, 1'b0};

        // Reset state.
        tick(2);
        check("rst_pixel", 32'(pixel), 32'd0);
        check("rst_mem_req", 32'(mem_if.mem_req), 32'd0);
        check("rst_mem_addr", 32'(mem_if.mem_addr), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));

        // First fetch after reset: line 1, zero-wait memory.
        mark();
        nReset = 1'b1;
        wait_idle();
        model_line[1] = 1;
        check_fetch("first_fetch", 1);
        check("first_req_cycles", 32'(req_cycles - cyc_mark), 32'd20);
        check("first_req_pulses", 32'(rises - rise_mark), 32'd20);
        check("first_overrun", 32'(overrun), 32'd0);
        read_px("line0_black", 100, exp_pix(100, 0));

        // Known line 2 pattern via the vector table.
        step_y(1, 1'b1);
        step_y(2, 1'b1);
        for (int i = 0; i < 12; i++) begin
            pixel_y = 10'(vecs[i].y);
            read_px($sformatf("vec%0d_x%0d", i, vecs[i].x), vecs[i].x, vecs[i].exp);
        end

        // Slow memory: five wait cycles per word.
        ack_delay = 5;
        mark();
        step_y(3, 1'b1);
        check_fetch("delay_fetch", 4);
        check("delay_req_cycles", 32'(req_cycles - cyc_mark), 32'd120);
        check("delay_req_pulses", 32'(rises - rise_mark), 32'd20);
        ack_delay = 0;
        step_y(4, 1'b1);
        for (int k = 0; k < 8; k++) begin
            x = $urandom_range(0, 639);
            read_px("delay_data", x, exp_pix(x, 4));
        end

        // Frame wrap and bottom edge.
        mark();
        step_y(523, 1'b1);
        check("no_fetch_at_523", 32'(rises - rise_mark), 32'd0);
        mark();
        step_y(524, 1'b1);
        check_fetch("wrap_fetch", 0);
        step_y(0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            x = $urandom_range(0, 799);
            read_px("wrap_line0", x, exp_pix(x, 0));
        end
        step_y(478, 1'b1);
        mark();
        step_y(479, 1'b1);
        check("no_fetch_at_479", 32'(rises - rise_mark), 32'd0);
        for (int k = 0; k < 4; k++) begin
            x = $urandom_range(0, 639);
            read_px("line479", x, exp_pix(x, 479));
        end
        step_y(480, 1'b1);
        read_px("blank_y480", 5, exp_pix(5, 480));
        read_px("blank_y480_b", 300, exp_pix(300, 480));

        // Overrun: stalled memory, then the line changes mid-fetch.
        ack_hold = 1'b1;
        step_y(10, 1'b0);
        tick(6);
        check("ovr_req_held", 32'(mem_if.mem_req), 32'd1);
        check("ovr_addr_held", 32'(mem_if.mem_addr), 32'(BASE + 220));
        check("ovr_before", 32'(overrun), 32'd0);
        mark();
        step_y(11, 1'b0);
        tick(1);
        check("ovr_set", 32'(overrun), 32'd1);
        check("ovr_restart_req", 32'(mem_if.mem_req), 32'd1);
        check("ovr_restart_addr", 32'(mem_if.mem_addr), 32'(BASE + 240));
        relatch_cnt++;
        ack_hold = 1'b0;
        wait_idle();
        model_line[0] = 12;
        check_fetch("ovr_refetch", 12);
        for (int k = 0; k < 4; k++) begin
            x = $urandom_range(0, 639);
            read_px("ovr_old_buf_black", x, exp_pix(x, 11));
        end
        check("ovr_sticky", 32'(overrun), 32'd1);

        // Reset in the middle of a fetch.
        ack_hold = 1'b1;
        step_y(20, 1'b0);
        tick(3);
        check("pre_rst_req", 32'(mem_if.mem_req), 32'd1);
        nReset = 1'b0;
        #1;
        check("rst_req_async", 32'(mem_if.mem_req), 32'd0);
        check("rst_pixel_mid", 32'(pixel), 32'd0);
        model_line[0] = -1;
        model_line[1] = -1;
        tick(2);
        mark();
        ack_hold = 1'b0;
        ack_rand = 1'b1;
        nReset   = 1'b1;
        wait_idle();
        model_line[1] = 21;
        check_fetch("rst_refetch", 21);
        check("rst_overrun_clear", 32'(overrun), 32'd0);
        read_px("rst_buf0_black", 40, exp_pix(40, 20));

        // Randomized line steps with random memory wait states.
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 1) == 1) y = (cur_y + 1) % 525;
            else y = $urandom_range(0, 524);
            step_y(y, 1'b1);
            for (int k = 0; k < 4; k++) begin
                x = $urandom_range(0, 799);
                read_px($sformatf("rand_y%0d_x%0d", y, x), x, exp_pix(x, y));
            end
        end
        check("rand_no_overrun", 32'(overrun), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
